sound_event_sequencer: RTL and testbench

//   Shares the single board speaker between the game's audio requesters: hit, wall, goal and match-win events.

---
 rtl/sound_event_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_sound_event_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_sequencer.sv
// Speaker arbiter for game audio: latches hit/wall/goal/win requests and plays
// one square-wave tone per event (or a three-note melody for a win) by fixed priority.
module sound_event_sequencer #(
   parameter logic [19:0] DIV_WALL  = 20'd100000,
   parameter logic [19:0] DIV_HIT   = 20'd50000,
   parameter logic [19:0] DIV_GOAL  = 20'd25000,
   parameter logic [23:0] DUR_SHORT = 24'd5000000,
   parameter logic [23:0] DUR_LONG  = 24'd12500000,
   parameter logic [23:0] GAP_CYC   = 24'd2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit,
   input  logic       wall,
   input  logic       goal,
   input  logic       p1_win,
   input  logic       p2_win,
   input  logic       mute,
   output logic       speaker,
   output logic       busy,
   output logic [2:0] cur_evt
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   localparam logic [2:0] EV_NONE = 3'd0;
   localparam logic [2:0] EV_WALL = 3'd1;
   localparam logic [2:0] EV_HIT  = 3'd2;
   localparam logic [2:0] EV_GOAL = 3'd3;
   localparam logic [2:0] EV_WIN  = 3'd4;

   state_t      r_state, w_stateNext;
   logic [2:0]  r_evt, w_evtNext;
   logic [1:0]  r_idx, w_idxNext;
   logic [19:0] r_tone, w_toneNext;
   logic [23:0] r_dur, w_durNext;
   logic        r_spk, w_spkNext;
   logic [3:0]  r_pend, w_pendNext;
   logic        r_winPrev;

   logic        w_winLvl;
   logic [3:0]  w_req;
   logic [3:0]  w_playMask;
   logic [3:0]  w_set;
   logic [3:0]  w_grant;
   logic [2:0]  w_topEvt;
   logic [3:0]  w_topMask;
   logic        w_preempt;
   logic [19:0] w_div;
   logic [23:0] w_noteLen;

   // Pending bits are ordered {win, goal, hit, wall}; the win request is the rising edge of either win level.
   assign w_winLvl = p1_win | p2_win;
   assign w_req    = {w_winLvl & ~r_winPrev, goal, hit, wall};
   assign w_set    = mute ? 4'b0000 : (w_req & ~w_playMask);

   // Decode the highest pending request and the mask of the event now sounding.
   always_comb begin
      w_topEvt   = EV_NONE;
      w_topMask  = 4'b0000;
      w_playMask = 4'b0000;
      if (r_pend[3]) begin
         w_topEvt  = EV_WIN;
         w_topMask = 4'b1000;
      end else if (r_pend[2]) begin
         w_topEvt  = EV_GOAL;
         w_topMask = 4'b0100;
      end else if (r_pend[1]) begin
         w_topEvt  = EV_HIT;
         w_topMask = 4'b0010;
      end else if (r_pend[0]) begin
         w_topEvt  = EV_WALL;
         w_topMask = 4'b0001;
      end
      if (r_state == S_PLAY) begin
         case (r_evt)
            EV_WALL: w_playMask = 4'b0001;
            EV_HIT:  w_playMask = 4'b0010;
            EV_GOAL: w_playMask = 4'b0100;
            EV_WIN:  w_playMask = 4'b1000;
            default: w_playMask = 4'b0000;
         endcase
      end
   end

   // Tone half-period and note length for the note currently playing; the win melody's middle note is the hit pitch.
   always_comb begin
      w_div     = DIV_GOAL;
      w_noteLen = DUR_LONG;
      case (r_evt)
         EV_WALL: begin
            w_div     = DIV_WALL;
            w_noteLen = DUR_SHORT;
         end
         EV_HIT: begin
            w_div     = DIV_HIT;
            w_noteLen = DUR_SHORT;
         end
         EV_WIN:  w_div = (r_idx == 2'd1) ? DIV_HIT : DIV_GOAL;
         default: w_div = DIV_GOAL;
      endcase
   end

   assign w_preempt = (((r_evt == EV_WALL) || (r_evt == EV_HIT)) && (r_pend[3] || r_pend[2]))
                    || ((r_evt == EV_GOAL) && r_pend[3]);

   // Next-state logic; preemption outranks the end of a note, and mute overrides everything.
   always_comb begin
      w_stateNext = r_state;
      w_evtNext   = r_evt;
      w_idxNext   = r_idx;
      w_toneNext  = r_tone;
      w_durNext   = r_dur;
      w_spkNext   = r_spk;
      w_grant     = 4'b0000;
      case (r_state)
         S_IDLE: begin
            if (w_topEvt != EV_NONE) begin
               w_stateNext = S_PLAY;
               w_evtNext   = w_topEvt;
               w_idxNext   = 2'd0;
               w_toneNext  = 20'd0;
               w_durNext   = 24'd0;
               w_spkNext   = 1'b0;
               w_grant     = w_topMask;
            end
         end
         S_PLAY: begin
            if (w_preempt) begin
               w_evtNext  = w_topEvt;
               w_idxNext  = 2'd0;
               w_toneNext = 20'd0;
               w_durNext  = 24'd0;
               w_spkNext  = 1'b0;
               w_grant    = w_topMask;
            end else begin
               if (r_tone == w_div - 20'd1) begin
                  w_toneNext = 20'd0;
                  w_spkNext  = ~r_spk;
               end else begin
                  w_toneNext = r_tone + 20'd1;
               end
               if (r_dur == w_noteLen - 24'd1) begin
                  w_toneNext = 20'd0;
                  w_durNext  = 24'd0;
                  w_spkNext  = 1'b0;
                  if ((r_evt == EV_WIN) && (r_idx != 2'd2)) begin
                     w_idxNext = r_idx + 2'd1;
                  end else begin
                     w_stateNext = S_GAP;
                     w_evtNext   = EV_NONE;
                     w_idxNext   = 2'd0;
                  end
               end else begin
                  w_durNext = r_dur + 24'd1;
               end
            end
         end
         S_GAP: begin
            if (r_dur == GAP_CYC - 24'd1) begin
               w_stateNext = S_IDLE;
               w_durNext   = 24'd0;
            end else begin
               w_durNext = r_dur + 24'd1;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
      w_pendNext = (r_pend | w_set) & ~w_grant;
      if (mute) begin
         w_stateNext = S_IDLE;
         w_evtNext   = EV_NONE;
         w_idxNext   = 2'd0;
         w_toneNext  = 20'd0;
         w_durNext   = 24'd0;
         w_spkNext   = 1'b0;
         w_pendNext  = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_evt     <= EV_NONE;
         r_idx     <= 2'd0;
         r_tone    <= 20'd0;
         r_dur     <= 24'd0;
         r_spk     <= 1'b0;
         r_pend    <= 4'b0000;
         r_winPrev <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_evt     <= w_evtNext;
         r_idx     <= w_idxNext;
         r_tone    <= w_toneNext;
         r_dur     <= w_durNext;
         r_spk     <= w_spkNext;
         r_pend    <= w_pendNext;
         r_winPrev <= w_winLvl;
      end
   end

   assign speaker = r_spk;
   assign busy    = (r_state != S_IDLE);
   assign cur_evt = (r_state == S_PLAY) ? r_evt : EV_NONE;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench for sound_event_sequencer: an event-level reference model predicts
// speaker/busy/cur_evt every cycle and a separate monitor compares them against the DUT.
module tb_sound_event_sequencer;

   localparam int DIV_WALL  = 6;
   localparam int DIV_HIT   = 4;
   localparam int DIV_GOAL  = 2;
   localparam int DUR_SHORT = 16;
   localparam int DUR_LONG  = 32;
   localparam int GAP_CYC   = 4;

   logic       clk;
   logic       rst;
   logic       hit, wall, goal, p1_win, p2_win, mute;
   logic       speaker, busy;
   logic [2:0] cur_evt;

   typedef struct packed {
      logic       spk;
      logic       busy;
      logic [2:0] evt;
   } exp_t;

   exp_t expQ[$];
   int   checkCount;
   int   errCount;

   sound_event_sequencer #(
      .DIV_WALL (20'(DIV_WALL)),
      .DIV_HIT  (20'(DIV_HIT)),
      .DIV_GOAL (20'(DIV_GOAL)),
      .DUR_SHORT(24'(DUR_SHORT)),
      .DUR_LONG (24'(DUR_LONG)),
      .GAP_CYC  (24'(GAP_CYC))
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .hit    (hit),
      .wall   (wall),
      .goal   (goal),
      .p1_win (p1_win),
      .p2_win (p2_win),
      .mute   (mute),
      .speaker(speaker),
      .busy   (busy),
      .cur_evt(cur_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a sound is described by its event code and cycles elapsed since it started.
   int mMode;      // 0 idle, 1 play, 2 gap
   int mEvt;
   int mT;
   int mGapLeft;
   bit mPrevWin;
   bit mPend[1:4];

   function automatic int soundLen(input int evt);
      if (evt == 4) return 3 * DUR_LONG;
      if (evt == 3) return DUR_LONG;
      return DUR_SHORT;
   endfunction

   function automatic int noteLen(input int evt);
      return (evt >= 3) ? DUR_LONG : DUR_SHORT;
   endfunction

   function automatic int halfPeriod(input int evt, input int t);
      if (evt == 1) return DIV_WALL;
      if (evt == 2) return DIV_HIT;
      if (evt == 3) return DIV_GOAL;
      return ((t / DUR_LONG) == 1) ? DIV_HIT : DIV_GOAL;
   endfunction

   always @(posedge clk) begin
      int   top;
      int   oldMode;
      int   oldEvt;
      int   granted;
      bit   req[1:4];
      bit   winLvl;
      exp_t e;
      int   k;
      if (rst) begin
         mMode = 0; mEvt = 0; mT = 0; mGapLeft = 0; mPrevWin = 0;
         for (int i = 1; i <= 4; i++) mPend[i] = 0;
      end else begin
         winLvl  = p1_win | p2_win;
         req[1]  = wall;
         req[2]  = hit;
         req[3]  = goal;
         req[4]  = winLvl && !mPrevWin;
         mPrevWin = winLvl;
         if (mute) begin
            mMode = 0; mEvt = 0; mT = 0; mGapLeft = 0;
            for (int i = 1; i <= 4; i++) mPend[i] = 0;
         end else begin
            top = 0;
            for (int i = 1; i <= 4; i++) if (mPend[i]) top = i;
            oldMode = mMode;
            oldEvt  = mEvt;
            granted = 0;
            if (mMode == 0) begin
               if (top != 0) begin
                  mMode = 1; mEvt = top; mT = 0; granted = top;
               end
            end else if (mMode == 1) begin
               if ((mEvt <= 2 && top >= 3) || (mEvt == 3 && top == 4)) begin
                  mEvt = top; mT = 0; granted = top;
               end else begin
                  mT++;
                  if (mT == soundLen(mEvt)) begin
                     mMode = 2; mEvt = 0; mT = 0; mGapLeft = GAP_CYC;
                  end
               end
            end else begin
               mGapLeft--;
               if (mGapLeft == 0) mMode = 0;
            end
            if (granted != 0) mPend[granted] = 0;
            for (int i = 1; i <= 4; i++)
               if (req[i] && !(oldMode == 1 && oldEvt == i) && i != granted) mPend[i] = 1;
         end
      end
      e.busy = (mMode != 0);
      e.evt  = (mMode == 1) ? 3'(mEvt) : 3'd0;
      e.spk  = 1'b0;
      if (mMode == 1) begin
         k     = mT % noteLen(mEvt);
         e.spk = ((k / halfPeriod(mEvt, mT)) % 2) == 1;
      end
      expQ.push_back(e);
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checkCount++;
      if (act != exp) begin
         errCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: each cycle the DUT presents a new output sample, compare it with the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("speaker", int'(speaker), int'(e.spk));
         checkOutput("busy", int'(busy), int'(e.busy));
         checkOutput("cur_evt", int'(cur_evt), int'(e.evt));
      end
   end

   task automatic applyStimulus(input bit iRst, input bit iHit, input bit iWall, input bit iGoal,
                                input bit iP1, input bit iP2, input bit iMute, input int cycles);
      rst = iRst; hit = iHit; wall = iWall; goal = iGoal;
      p1_win = iP1; p2_win = iP2; mute = iMute;
      @(posedge clk);
      #1;
      hit = 1'b0; wall = 1'b0; goal = 1'b0; rst = 1'b0;
      for (int i = 1; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bit lvl1, lvl2, mt;
      int waitCyc;
      checkCount = 0;
      errCount   = 0;
      rst = 1'b1; hit = 1'b0; wall = 1'b0; goal = 1'b0;
      p1_win = 1'b0; p2_win = 1'b0; mute = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 6);
      // single hit, then wall+hit together
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 30);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 60);
      // goal preempts a playing hit
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 7);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 50);
      // held win: one melody only
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 150);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
      // repeated hits during hit, repeated walls while blocked
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 4);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 3);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 3);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 60);
      // mute mid-goal, then reset mid-win
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 12);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 20);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 40);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 20);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 10);
      // randomized traffic
      lvl1 = 0; lvl2 = 0; mt = 0;
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 299) == 0) lvl1 = ~lvl1;
         if ($urandom_range(0, 399) == 0) lvl2 = ~lvl2;
         if (mt) begin
            if ($urandom_range(0, 7) == 0) mt = 0;
         end else if ($urandom_range(0, 499) == 0) begin
            mt = 1;
         end
         applyStimulus($urandom_range(0, 1499) == 0,
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 34) == 0,
                       $urandom_range(0, 89) == 0,
                       lvl1, lvl2, mt, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
      waitCyc = 0;
      while (expQ.size() > 0 && waitCyc < 10) begin
         @(posedge clk);
         waitCyc++;
      end
      @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         checkCount++;
         errCount++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
